// File: rtl/pb_pkg.sv
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared types and default timing constants for the push-button
//                press generator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pb_pkg;

    // Press sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FALL = 3'd1,
        HOLD = 3'd2,
        RISE = 3'd3,
        GAP  = 3'd4
    } pb_state_t;

    localparam int PB_HOLD_W       = 16;
    localparam int PB_BOUNCE_EDGES = 5;
    localparam int PB_BOUNCE_CYC   = 16;
    localparam int PB_GAP_CYC      = 64;

    // Larger of two integers, used to size the shared down-counter
    function automatic int pb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pb_press_gen_cyc_timer.sv
// ============================================================================
//  Module      : cyc_timer
//  Description : Loadable down-counter that saturates at zero. Flags the
//                final cycle (count zero) and the cycle before it (count one).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over decrement; the count never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/pb_press_gen.sv
// ============================================================================
//  Module      : pb_press_gen
//  Description : Drives an active-low push-button line with one complete
//                press/release waveform per accepted request, optionally with
//                contact bounce on both edges, followed by a high gap.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pb_press_gen
    import pb_pkg::*;
#(
    parameter int HOLD_W       = PB_HOLD_W,
    parameter int BOUNCE_EDGES = PB_BOUNCE_EDGES,
    parameter int BOUNCE_CYC   = PB_BOUNCE_CYC,
    parameter int GAP_CYC      = PB_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [HOLD_W-1:0] hold_cyc,
    input  logic              bounce_en,
    input  logic              abort,
    output logic              PB,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = pb_max(HOLD_W, $clog2(pb_max(BOUNCE_CYC, GAP_CYC)) + 1);
    localparam int EDGE_W = $clog2(BOUNCE_EDGES + 1);

    localparam logic [CNT_W-1:0]  C_BC_LOAD   = CNT_W'(BOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [EDGE_W-1:0] C_EDGE_LOAD = EDGE_W'(BOUNCE_EDGES - 1);
    localparam logic              C_GAP_ONE   = (GAP_CYC == 1);
    localparam logic              C_HAS_BNC   = (BOUNCE_EDGES > 1);

    // A zero hold request still produces a one-cycle press
    function automatic logic [CNT_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : CNT_W'(h - HOLD_W'(1));
    endfunction

    // ------------------------------------------------------------------------
    // Reset: asserted asynchronously, released in step with clk
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Two-stage release synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------------
    pb_state_t         state_q, state_d;
    logic              pb_q, pb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              bounce_q, bounce_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_dec;
    logic              tmr_zero;
    logic              tmr_one;

    assign tmr_dec = (state_q != IDLE);

    cyc_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    // Next-state, next-output and timer-load decisions for the press sequence
    always_comb begin
        state_d  = state_q;
        pb_d     = pb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hold_d   = hold_q;
        bounce_d = bounce_q;
        edge_d   = edge_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    hold_d   = hold_cyc;
                    bounce_d = bounce_en;
                    pb_d     = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    if (bounce_en && C_HAS_BNC) begin
                        state_d = FALL;
                        tmr_val = C_BC_LOAD;
                        edge_d  = C_EDGE_LOAD;
                    end else begin
                        state_d = HOLD;
                        tmr_val = hold_load(hold_cyc);
                    end
                end
            end
            FALL: begin
                if (tmr_zero) begin
                    pb_d     = ~pb_q;
                    tmr_load = 1'b1;
                    if (edge_q == EDGE_W'(1)) begin
                        // Final low level of the burst doubles as the first HOLD cycle
                        state_d = HOLD;
                        tmr_val = hold_load(hold_q);
                        edge_d  = '0;
                    end else begin
                        edge_d  = edge_q - EDGE_W'(1);
                        tmr_val = C_BC_LOAD;
                    end
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    pb_d     = 1'b1;
                    tmr_load = 1'b1;
                    if (bounce_q && C_HAS_BNC) begin
                        state_d = RISE;
                        tmr_val = C_BC_LOAD;
                        edge_d  = C_EDGE_LOAD;
                    end else begin
                        state_d = GAP;
                        tmr_val = C_GAP_LOAD;
                        done_d  = C_GAP_ONE;
                    end
                end
            end
            RISE: begin
                if (tmr_zero) begin
                    pb_d     = ~pb_q;
                    tmr_load = 1'b1;
                    if (edge_q == EDGE_W'(1)) begin
                        // Final high level of the burst is the first GAP cycle
                        state_d = GAP;
                        tmr_val = C_GAP_LOAD;
                        edge_d  = '0;
                        done_d  = C_GAP_ONE;
                    end else begin
                        edge_d  = edge_q - EDGE_W'(1);
                        tmr_val = C_BC_LOAD;
                    end
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d  = tmr_one;
                end
            end
            default: begin
                state_d = IDLE;
                pb_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Abort cuts any active press short; IDLE and GAP ignore it
        if (abort && ((state_q == FALL) || (state_q == HOLD) || (state_q == RISE))) begin
            state_d  = GAP;
            pb_d     = 1'b1;
            busy_d   = 1'b1;
            edge_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = C_GAP_LOAD;
            done_d   = C_GAP_ONE;
        end
    end

    // Sequencer registers; all outputs come straight from flops
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            pb_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= '0;
            bounce_q <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            pb_q     <= pb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            bounce_q <= bounce_d;
            edge_q   <= edge_d;
        end
    end

    assign PB   = pb_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pb_press_gen.sv
// ============================================================================
//  Module      : tb_pb_press_gen
//  Description : Self-checking bench for pb_press_gen. A reference waveform
//                for each press is queued when the request is driven and
//                compared cycle by cycle against PB, busy and done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pb_press_gen;

    localparam int HOLD_W = 16;
    localparam int EDGES  = 5;
    localparam int BC     = 16;
    localparam int GAPC   = 64;

    typedef struct packed {
        logic pb;
        logic busy;
        logic done;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic [HOLD_W-1:0] hold_cyc;
    logic              bounce_en;
    logic              abort;
    logic              PB;
    logic              busy;
    logic              done;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    pb_press_gen #(
        .HOLD_W       (HOLD_W),
        .BOUNCE_EDGES (EDGES),
        .BOUNCE_CYC   (BC),
        .GAP_CYC      (GAPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .hold_cyc  (hold_cyc),
        .bounce_en (bounce_en),
        .abort     (abort),
        .PB        (PB),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    // Reference waveform of one press, starting with the first busy cycle.
    // ab = cycle in which abort is high (0 = none).
    task automatic build_exp(input int h, input bit b, input int ab);
        int   heff;
        bit   lv[$];
        exp_t e;
        heff = (h == 0) ? 1 : h;
        if (b) begin
            for (int k = 0; k < EDGES - 1; k++)
                for (int c = 0; c < BC; c++) lv.push_back(k % 2 == 1);
        end
        for (int c = 0; c < heff; c++) lv.push_back(1'b0);
        if (b) begin
            for (int k = 0; k < EDGES - 1; k++)
                for (int c = 0; c < BC; c++) lv.push_back(k % 2 == 0);
        end
        if (ab >= 1 && ab < lv.size()) begin
            while (lv.size() > ab) void'(lv.pop_back());
        end
        foreach (lv[i]) begin
            e.pb = lv[i]; e.busy = 1'b1; e.done = 1'b0;
            sb.push_back(e);
        end
        for (int g = 0; g < GAPC; g++) begin
            e.pb = 1'b1; e.busy = 1'b1; e.done = (g == GAPC - 1);
            sb.push_back(e);
        end
    endtask

    // One press: request in the first idle cycle, then compare every cycle.
    // req_at: cycle with an extra (ignored) request; stop_at: leave early.
    task automatic run_press(input int h, input bit b, input int ab, input int req_at,
                             input bit abort_with_req, input int stop_at);
        exp_t e;
        int   j;
        @(negedge clk);
        check_eq("idle_pb", PB, 1);
        check_eq("idle_busy", busy, 0);
        req       = 1'b1;
        hold_cyc  = HOLD_W'(h);
        bounce_en = b;
        abort     = abort_with_req;
        build_exp(h, b, ab);
        @(posedge clk);
        j = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            j++;
            req   = (j == req_at);
            abort = (j == ab);
            e = sb.pop_front();
            check_eq("pb", PB, e.pb);
            check_eq("busy", busy, e.busy);
            check_eq("done", done, e.done);
            if (j == stop_at) break;
        end
        req   = 1'b0;
        abort = 1'b0;
        sb.delete();
    endtask

    initial begin
        int dones;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 1'b0;
        hold_cyc  = '0;
        bounce_en = 1'b0;
        abort     = 1'b0;

        // Reset state, then quiet after release
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pb", PB, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_pb", PB, 1);
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_done", done, 0);
        end

        // Clean and bounced presses
        run_press(10, 1'b0, 0, 0, 1'b0, 0);
        run_press(100, 1'b1, 0, 0, 1'b0, 0);

        // Request while busy ignored; request right after done accepted
        run_press(10, 1'b0, 0, 5, 1'b0, 0);
        run_press(20, 1'b0, 0, 0, 1'b0, 0);

        // Abort: mid-hold clean, mid-hold bounced, in GAP, together with req
        run_press(1000, 1'b0, 20, 0, 1'b0, 0);
        run_press(100, 1'b1, 70, 0, 1'b0, 0);
        run_press(100, 1'b1, 30, 0, 1'b0, 0);
        run_press(10, 1'b0, 30, 0, 1'b0, 0);
        run_press(10, 1'b0, 0, 0, 1'b1, 0);

        // Zero hold is a one-cycle press
        run_press(0, 1'b0, 0, 0, 1'b0, 0);
        run_press(0, 1'b1, 0, 0, 1'b0, 0);

        // Reset asserted mid-HOLD: PB high at once, no done afterwards
        run_press(50, 1'b0, 0, 0, 1'b0, 20);
        check_eq("pre_rst_pb_low", PB, 0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_pb", PB, 1);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("no_done_after_rst", dones, 0);
        check_eq("idle_after_rst_pb", PB, 1);

        // Still functional after the mid-press reset
        run_press(7, 1'b0, 0, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
